// File: rtl/imem_pkg.sv
// Shared types and constants for the byte-serialized instruction memory sequencer.
package imem_pkg;
  localparam int IMEM_ADDR_W    = 10;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} imem_state_t;
  typedef enum logic {GNT_IF, GNT_LD} gnt_src_t;

  // Big-endian byte select: idx 0 is word[31:24], idx 3 is word[7:0].
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [31:0] s;
    s = w << {idx, 3'b000};
    return s[31:24];
  endfunction
endpackage

// File: rtl/imem_access_ctrl_rr_arbiter2.sv
// Two-requester round-robin arbiter; last_grant only moves when a grant is issued.
module rr_arbiter2
  import imem_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     en,
  input  logic     req_if,
  input  logic     req_ld,
  output logic     gnt_valid,
  output gnt_src_t gnt_src
);
  gnt_src_t last_grant_q, last_grant_d;

  always_comb begin
    gnt_valid = en & (req_if | req_ld);
    gnt_src   = GNT_IF;
    if (req_if && req_ld)
      gnt_src = (last_grant_q == GNT_IF) ? GNT_LD : GNT_IF;
    else if (req_ld)
      gnt_src = GNT_LD;
    last_grant_d = gnt_valid ? gnt_src : last_grant_q;
  end

  // Starting at "fetch" hands the loader the first conflict after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) last_grant_q <= GNT_IF;
    else        last_grant_q <= last_grant_d;
  end
endmodule

// File: rtl/imem_access_ctrl.sv
// Arbitrates fetch reads and loader writes onto a single-port byte RAM,
// serializing each 32-bit big-endian word into four byte accesses.
module imem_access_ctrl
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_done,
  output logic [31:0]       if_rdata,
  input  logic              ld_req,
  input  logic [31:0]       ld_addr,
  input  logic [31:0]       ld_wdata,
  output logic              ld_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);
  imem_state_t       state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [23:0]       shift_q, shift_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic              if_done_q, if_done_d;
  logic              ld_done_q, ld_done_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic [1:0]        off;
  logic              gnt_valid;
  gnt_src_t          gnt_src;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_W], ld_addr[31:ADDR_W]};

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (state_q == IDLE),
    .req_if   (if_req),
    .req_ld   (ld_req),
    .gnt_valid(gnt_valid),
    .gnt_src  (gnt_src)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    shift_d    = shift_q;
    if_rdata_d = if_rdata_q;
    if_done_d  = 1'b0;
    ld_done_d  = 1'b0;
    unique case (state_q)
      IDLE: if (gnt_valid) begin
        cnt_d = 3'd0;
        if (gnt_src == GNT_IF) begin
          base_d  = if_addr[ADDR_W-1:0];
          state_d = RD;
        end else begin
          base_d  = ld_addr[ADDR_W-1:0];
          wdata_d = ld_wdata;
          state_d = WR;
        end
      end
      RD: begin
        // RAM data lags the address by one cycle, so byte cnt-1 lands here.
        if (cnt_q != 3'd0) shift_d = {shift_q[15:0], mem_rdata};
        if (cnt_q == 3'd4) begin
          if_rdata_d = {shift_q, mem_rdata};
          if_done_d  = 1'b1;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      WR: begin
        if (cnt_q == 3'd3) begin
          ld_done_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Memory outputs are registered, so derive them from the next state.
    off         = (cnt_d == 3'd4) ? 2'd3 : cnt_d[1:0];
    mem_addr_d  = '0;
    mem_we_d    = 1'b0;
    mem_wdata_d = 8'h00;
    if (state_d == RD) begin
      mem_addr_d = base_d + ADDR_W'(off);
    end else if (state_d == WR) begin
      mem_addr_d  = base_d + ADDR_W'(off);
      mem_we_d    = 1'b1;
      mem_wdata_d = word_byte(wdata_d, off);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      base_q      <= '0;
      wdata_q     <= 32'h0;
      shift_q     <= 24'h0;
      if_rdata_q  <= 32'h0;
      if_done_q   <= 1'b0;
      ld_done_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      shift_q     <= shift_d;
      if_rdata_q  <= if_rdata_d;
      if_done_q   <= if_done_d;
      ld_done_q   <= ld_done_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Write enable is cut combinationally so a reset never commits the in-flight byte.
  assign mem_we    = mem_we_q & rst_n;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_done   = if_done_q;
  assign ld_done   = ld_done_q;
  assign if_rdata  = if_rdata_q;
  assign busy      = (state_q != IDLE);
endmodule

// File: doc/imem_access_ctrl.md
# imem_access_ctrl

Sequencer and arbiter for the byte-wide (8-bit × 1024) instruction memory in the MIPS core. It shares a single synchronous-read, single-port byte RAM between two requesters. The instruction-fetch unit reads 32-bit big-endian words. The boot/debug loader writes 32-bit words. Each word access is serialized into four byte accesses.

## Interface
- `ADDR_W`, default 10: byte-address width of the RAM (1024 bytes).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `if_req`  in  1  fetch request; held high until `if_done`.
- `if_addr`  in  32  fetch byte address; low `ADDR_W` bits used.
- `if_done`  out  1  one-cycle pulse; `if_rdata` valid.
- `if_rdata`  out  32  fetched word; held until the next fetch completes.
- `ld_req`  in  1  loader write request; held high until `ld_done`.
- `ld_addr`  in  32  loader byte address; low `ADDR_W` bits used.
- `ld_wdata`  in  32  loader write word.
- `ld_done`  out  1  one-cycle pulse; write complete.
- `mem_addr`  out  ADDR_W  RAM byte address.
- `mem_we`  out  1  RAM write enable.
- `mem_wdata`  out  8  RAM write byte.
- `mem_rdata`  in  8  RAM read byte; valid the cycle after `mem_addr` is presented with `mem_we`=0.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- States:
  - IDLE: requests are sampled here only.
  - RD: 5 cycles, counter 0..4.
  - WR: 4 cycles, counter 0..3.
  - DONE: 1 cycle.
- Transitions:
  - IDLE→RD/WR on grant.
  - RD(cnt=4)→DONE.
  - WR(cnt=3)→DONE.
  - DONE→IDLE unconditionally.
- Arbitration in IDLE:
  - A single request is granted directly.
  - When both `if_req` and `ld_req` are high, the grant goes round-robin to the requester not served last.
  - `last_grant` resets to "fetch", so the loader wins the first conflict after reset.
- On grant:
  - Latch base = addr[ADDR_W-1:0].
  - For a loader grant, also latch `ld_wdata`.
  - Later changes on request inputs are ignored until DONE.
- Byte address: `mem_addr` = base + k, computed modulo 2^ADDR_W. Addresses wrap from 1023 to 0. No alignment check; misaligned words are legal.
- Byte order is big-endian: byte at base ↔ word[31:24], base+3 ↔ word[7:0].
- RD:
  - For cnt 0..3, present base+cnt with `mem_we`=0.
  - For cnt 1..4, capture `mem_rdata` into byte cnt-1 of a shift register.
  - In cnt=4, `mem_addr` holds base+3.
- WR: for cnt 0..3, present base+cnt with `mem_we`=1 and `mem_wdata` = byte cnt of the latched word.
- DONE:
  - Pulse `if_done` (read) or `ld_done` (write).
  - `if_rdata` updates at the edge entering DONE.
  - A requester deasserts `req` after seeing its done pulse, or keeps it high with a new address for the next IDLE sample.
- Outputs outside RD/WR: `mem_addr`=0, `mem_we`=0, `mem_wdata`=0.
- Reset values: every output is 0 (`if_rdata`=32'h0, `busy`=0). State is IDLE.
- Reset mid-operation:
  - Abort immediately to IDLE; no done pulse.
  - `mem_we` drops in the reset cycle.
  - Bytes already written stay written.

## Timing
- G = the edge at which IDLE grants.
- Read:
  - Address cycles G+1..G+4.
  - Captures at edges G+2..G+5.
  - `if_done`=1 in cycle G+6.
  - IDLE again in cycle G+7.
  - Total latency: 6 cycles from grant to done.
- Write:
  - `mem_we`=1 in cycles G+1..G+4.
  - `ld_done`=1 in cycle G+5.
  - IDLE in cycle G+6.
- Minimum spacing between consecutive grants: 7 cycles (read), 6 cycles (write).
- Worst-case wait for one requester under contention: one full transaction of the other, plus one IDLE cycle.

## Structure
- Shared package `imem_pkg`:
  - `IMEM_ADDR_W` = 10.
  - `BYTES_PER_WORD` = 4.
  - State enum `imem_state_t` {IDLE, RD, WR, DONE}.
  - Grant-source enum {GNT_IF, GNT_LD}.
- Sub-module `rr_arbiter2`: two-requester round-robin with registered `last_grant`, updated only on grant.
- The byte RAM is external to this block.

## Test plan
- Aligned read: RAM[0x10..0x13] = 8C,22,00,04; `if_req` with `if_addr`=0x10 → `if_done` exactly 6 cycles after grant, `if_rdata`=32'h8C220004.
- Loader write then fetch read: write `ld_wdata`=32'hDEADBEEF to 0x20 → `mem_we` high 4 cycles with bytes DE,AD,BE,EF at 0x20..0x23. Fetch of 0x20 then returns 32'hDEADBEEF.
- Wrap: read at 0x3FE with RAM[3FE,3FF,000,001] = 11,22,33,44 → `mem_addr` sequence 3FE,3FF,000,001; `if_rdata`=32'h11223344.
- Contention after reset: `if_req` and `ld_req` both high in IDLE → loader served first; fetch granted in the next IDLE and served second. With both kept high, grants alternate LD, IF, LD, IF.
- Reset mid-write: `rst_n`=0 in cycle G+3 of a write to 0x40 → no `ld_done`, state IDLE, `mem_we`=0 in that cycle. RAM 0x40..0x41 hold the written bytes and 0x42..0x43 are unchanged.
- Input change during transaction: `if_addr` changed from 0x10 to 0x50 in cycle G+2 → `mem_addr` stays at 0x10..0x13; the result reflects 0x10.
